// File: rtl/div32_seq_pkg.sv
// div_pkg: shared operand width and divider FSM state encoding.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;
endpackage

// File: rtl/div32_seq_if.sv
// div32_seq_if: request (start/operands) and result bus of the sequential divider.
interface div32_seq_if;
    import div_pkg::*;
    logic                 start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 div_by_zero;
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div32_seq_cla32.sv
// cla32: 32-bit adder built from 4-bit carry-lookahead groups chained group to group.
module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic        o_ovf
);
    logic [31:0] w_g, w_p;
    logic [32:0] w_c;
    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
            w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (&w_p[4*k+:4] & w_c[4*k]);
        end
    end
    assign o_sum  = w_p ^ w_c[31:0];
    assign o_cout = w_c[32];
    assign o_ovf  = w_c[32] ^ w_c[31];
endmodule

// File: rtl/div32_seq.sv
// div32_seq: unsigned restoring divider, one quotient bit per cycle,
// trial subtraction done by cla32 adding the inverted divisor.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    div32_seq_if.slave  bus
);
    state_t           r_state, w_next;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_quo, r_rmd;
    logic             r_dbz;
    logic [WIDTH-1:0] w_shift, w_trial, w_rem_nx, w_q_nx;
    logic             w_cout, w_accept, w_unused_ovf;

    assign w_shift = {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    cla32 u_sub (
        .i_a(w_shift), .i_b(~r_dvs), .i_cin(1'b1),
        .o_sum(w_trial), .o_cout(w_cout), .o_ovf(w_unused_ovf)
    );
    // A bit shifted out of rem means shifted >= 2^W > divisor, so the trial always fits.
    assign w_accept = w_cout | r_rem[WIDTH-1];
    assign w_rem_nx = w_accept ? w_trial : w_shift;
    assign w_q_nx   = {r_dvd[WIDTH-2:0], w_accept};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.divisor == '0) ? DONE_ST : RUN;
            RUN:     if (r_cnt == '0) w_next = DONE_ST;
            default: w_next = IDLE;
        endcase
    end

    assign bus.busy        = r_state != IDLE;
    assign bus.done        = r_state == DONE_ST;
    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rmd;
    assign bus.div_by_zero = r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quo   <= '0;
            r_rmd   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_dvd <= bus.dividend;
                r_dvs <= bus.divisor;
                r_rem <= '0;
                r_cnt <= 5'(WIDTH-1);
                if (bus.divisor == '0) begin
                    r_quo <= '1;
                    r_rmd <= bus.dividend;
                    r_dbz <= 1'b1;
                end
            end else if (r_state == RUN) begin
                r_rem <= w_rem_nx;
                r_dvd <= w_q_nx;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == '0) begin
                    r_quo <= w_q_nx;
                    r_rmd <= w_rem_nx;
                    r_dbz <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed vector table plus busy-start and mid-run reset sequences.
module tb_div32_seq;
    typedef struct {
        logic [31:0] dvd, dvs, q, r;
        logic        z;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t v [10];

    div32_seq_if bus_if ();
    div32_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat);
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.dividend = a;
        bus_if.divisor  = b;
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            lat++;
            if (bus_if.done) break;
        end
        q = bus_if.quotient;
        r = bus_if.remainder;
        z = bus_if.div_by_zero;
    endtask

    initial begin
        logic [31:0] q, r, fq, fr;
        logic        z;
        int          lat, dn, first;
        v[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        v[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 33};
        v[2] = '{32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 33};
        v[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33};
        v[4] = '{32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 33};
        v[5] = '{32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1, 1};
        v[6] = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0, 33};
        v[7] = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0, 33};
        v[8] = '{32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0, 33};
        v[9] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33};
        bus_if.start    = 1'b0;
        bus_if.dividend = '0;
        bus_if.divisor  = '0;
        #12;
        chk("reset busy", 32'(bus_if.busy), 32'd0);
        chk("reset done", 32'(bus_if.done), 32'd0);
        chk("reset quotient", bus_if.quotient, 32'd0);
        chk("reset remainder", bus_if.remainder, 32'd0);
        chk("reset dbz", 32'(bus_if.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_div(v[i].dvd, v[i].dvs, q, r, z, lat);
            chk($sformatf("vec%0d quotient", i), q, v[i].q);
            chk($sformatf("vec%0d remainder", i), r, v[i].r);
            chk($sformatf("vec%0d dbz", i), 32'(z), 32'(v[i].z));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(v[i].lat));
        end
        // Second start while busy must be ignored.
        dn = 0;
        first = 0;
        fq = '0;
        fr = '0;
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.dividend = 32'd100;
        bus_if.divisor  = 32'd7;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            bus_if.start = (c == 5);
            if (c == 5) begin
                bus_if.dividend = 32'd50;
                bus_if.divisor  = 32'd5;
                chk("busy while running", 32'(bus_if.busy), 32'd1);
            end
            if (bus_if.done) begin
                dn++;
                if (dn == 1) begin
                    first = c;
                    fq = bus_if.quotient;
                    fr = bus_if.remainder;
                end
            end
        end
        chk("busy-start done count", 32'(dn), 32'd1);
        chk("busy-start latency", 32'(first), 32'd33);
        chk("busy-start quotient", fq, 32'd14);
        chk("busy-start remainder", fr, 32'd2);
        chk("held quotient", bus_if.quotient, 32'd14);
        chk("held remainder", bus_if.remainder, 32'd2);
        // Asynchronous reset in RUN cycle 10.
        @(negedge clk);
        bus_if.start    = 1'b1;
        bus_if.dividend = 32'd100;
        bus_if.divisor  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 32'(bus_if.busy), 32'd0);
        chk("midrun reset done", 32'(bus_if.done), 32'd0);
        chk("midrun reset quotient", bus_if.quotient, 32'd0);
        chk("midrun reset remainder", bus_if.remainder, 32'd0);
        chk("midrun reset dbz", 32'(bus_if.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(32'd81, 32'd9, q, r, z, lat);
        chk("post-reset quotient", q, 32'd9);
        chk("post-reset remainder", r, 32'd0);
        chk("post-reset dbz", 32'(z), 32'd0);
        chk("post-reset latency", 32'(lat), 32'd33);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
